pipeline_hazard_controller: RTL
===============================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameter MULDIV_CYCLES, default 4, range 2..15: number of cycles a mult/div occupies the HI/LO unit after issue.
REQ-002 Parameter CNT_W, default 16: width of the stall-cycle statistics counter.
REQ-003 Clk  input  1  single clock; all state SHALL update on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 ID_Rs  input  5  rs field of the instruction in ID.
REQ-006 ID_Rt  input  5  rt field of the instruction in ID.
REQ-007 ID_UsesRt  input  1  ID instruction reads rt.
REQ-008 ID_MulDiv  input  1  ID instruction is mult/multu/div/divu.
REQ-009 ID_HiLoRead  input  1  ID instruction is mfhi/mflo.
REQ-010 EX_MemRead  input  1  instruction in EX is a load.
REQ-011 EX_WriteAddress  input  5  destination register of the EX instruction.
REQ-012 MEM_BranchTaken  input  1  branch resolved taken in MEM.
REQ-013 PCWrite  output  1  PC update enable.
REQ-014 IF_ID_Write  output  1  IF/ID register load enable.
REQ-015 IF_ID_Flush  output  1  clear IF/ID to NOP.
REQ-016 ID_EX_Bubble  output  1  zero all ID/EX control bits.
REQ-017 EX_MEM_Flush  output  1  zero EX/MEM RegWrite, MemWrite, MemRead, Branch.
REQ-018 MulDivBusy  output  1  HI/LO unit occupied.
REQ-019 StallCycles  output  CNT_W  count of cycles with PCWrite=0.

Function
REQ-020 LoadUse SHALL be EX_MemRead & (EX_WriteAddress!=0) & ((EX_WriteAddress==ID_Rs) | (ID_UsesRt & EX_WriteAddress==ID_Rt)).
REQ-021 HiLoHaz SHALL be MulDivBusy & (ID_HiLoRead | ID_MulDiv).
REQ-022 State register SHALL hold one of RUN, STALL, FLUSH; outputs SHALL be combinational from state, counter and current inputs.
REQ-023 Priority, highest first: MEM_BranchTaken, LoadUse, HiLoHaz, none.
REQ-024 MEM_BranchTaken=1 -> same cycle: IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Flush=1, PCWrite=1, IF_ID_Write=1; next state FLUSH.
REQ-025 LoadUse or HiLoHaz (no branch) -> same cycle: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, flushes 0; next state STALL.
REQ-026 No hazard -> PCWrite=1, IF_ID_Write=1, all flush/bubble 0; next state RUN.
REQ-027 Load-use stall SHALL last exactly 1 cycle for an isolated hazard (load advances out of EX).
REQ-028 MulDiv counter (4 bits) SHALL load MULDIV_CYCLES when ID_MulDiv=1 with no stall and no branch in that cycle (instruction issues), else decrement by 1 when nonzero, saturating at 0.
REQ-029 MulDivBusy SHALL equal (counter!=0).
REQ-030 A mult/div already issued SHALL NOT be cancelled by a later branch flush; counter continues.
REQ-031 An ID_MulDiv flushed by MEM_BranchTaken in the same cycle SHALL NOT load the counter.
REQ-032 mfhi/mflo following mult in the next cycle SHALL stall MULDIV_CYCLES cycles total, then proceed with counter=0.
REQ-033 StallCycles SHALL increment by 1 each cycle PCWrite=0, saturating at all-ones.
REQ-034 FLUSH and STALL SHALL return to RUN on the next hazard-free cycle; state is informational and SHALL NOT extend any stall.

Reset
REQ-035 Reset=1 at posedge SHALL set state=RUN, counter=0, StallCycles=0, overriding all inputs, including mid-stall or mid-mult.
REQ-036 During and after reset with no hazard inputs: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, EX_MEM_Flush=0, MulDivBusy=0.

Verification
REQ-037 EX_MemRead=1, EX_WriteAddress=5, ID_Rs=5 one cycle -> PCWrite=0, ID_EX_Bubble=1 that cycle only; StallCycles=1; EX_WriteAddress=0 same case -> no stall.
REQ-038 Issue ID_MulDiv (MULDIV_CYCLES=4), next cycle ID_HiLoRead held -> PCWrite=0 for 4 cycles, MulDivBusy falls with stall release; StallCycles=4.
REQ-039 LoadUse and MEM_BranchTaken same cycle -> IF_ID_Flush=ID_EX_Bubble=EX_MEM_Flush=1, PCWrite=1; StallCycles unchanged.
REQ-040 ID_MulDiv with MEM_BranchTaken same cycle -> counter stays 0, MulDivBusy=0 next cycle.
REQ-041 Reset asserted in 2nd cycle of mult-busy stall -> next cycle MulDivBusy=0, PCWrite=1, StallCycles=0.
REQ-042 Force >=2^CNT_W stall cycles (or CNT_W=4 build, 20 stalls) -> StallCycles holds at all-ones.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard control for a 5-stage MIPS-style pipeline: load-use and HI/LO interlocks,
// branch flushes, a mult/div occupancy counter and a saturating stall-cycle counter.
module pipeline_hazard_controller #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_MulDiv,
    input  logic             ID_HiLoRead,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteAddress,
    input  logic             MEM_BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Flush,
    output logic             MulDivBusy,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic [1:0] {StRun, StStall, StFlush} state_t;

    state_t           stateQ, stateD;
    logic [3:0]       mulDivCntQ, mulDivCntD;
    logic [CNT_W-1:0] stallCyclesQ, stallCyclesD;

    logic loadUse, hiLoHaz, stall;

    assign loadUse = EX_MemRead && (EX_WriteAddress != 5'd0) &&
                     ((EX_WriteAddress == ID_Rs) || (ID_UsesRt && (EX_WriteAddress == ID_Rt)));
    assign MulDivBusy = (mulDivCntQ != 4'd0);
    assign hiLoHaz    = MulDivBusy && (ID_HiLoRead || ID_MulDiv);
    // A taken branch kills the ID instruction, so it outranks any interlock on it.
    assign stall      = !MEM_BranchTaken && (loadUse || hiLoHaz);

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        EX_MEM_Flush = 1'b0;
        if (MEM_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
            EX_MEM_Flush = 1'b1;
        end else if (stall) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

    // State is informational only; every legal state moves on the current hazards.
    always_comb begin
        stateD = StRun;
        case (stateQ)
            StRun, StStall, StFlush: begin
                if (MEM_BranchTaken) begin
                    stateD = StFlush;
                end else if (stall) begin
                    stateD = StStall;
                end else begin
                    stateD = StRun;
                end
            end
            default: stateD = StRun;
        endcase
    end

    always_comb begin
        mulDivCntD = mulDivCntQ;
        if (ID_MulDiv && !stall && !MEM_BranchTaken) begin
            mulDivCntD = 4'(MULDIV_CYCLES);
        end else if (mulDivCntQ != 4'd0) begin
            mulDivCntD = mulDivCntQ - 4'd1;
        end
    end

    always_comb begin
        stallCyclesD = stallCyclesQ;
        if (!PCWrite && (stallCyclesQ != {CNT_W{1'b1}})) begin
            stallCyclesD = stallCyclesQ + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            stateQ       <= StRun;
            mulDivCntQ   <= 4'd0;
            stallCyclesQ <= '0;
        end else begin
            stateQ       <= stateD;
            mulDivCntQ   <= mulDivCntD;
            stallCyclesQ <= stallCyclesD;
        end
    end

    assign StallCycles = stallCyclesQ;

endmodule
